// File: rtl/l_seq_pkg.sv
// Shared constants and state encoding for the L-transform sequencer.
package l_seq_pkg;

    localparam int unsigned N_BYTES = 16;
    localparam int unsigned STEP_W  = 4;
    localparam int unsigned BYTE_W  = 8;

    // Last issue step; the counter wraps to 0 as the FSM leaves ISSUE.
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } l_state_e;

endpackage

// File: rtl/l_seq.sv
// L-transform sequencer: walks the 16 input bytes through an external
// table ROM bank (one lookup per cycle) and XOR-accumulates the results.
module l_seq
    import l_seq_pkg::*;
#(
    parameter int unsigned W = 128
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        in_dat,
    output logic [STEP_W-1:0]   rom_sel,
    output logic [BYTE_W-1:0]   rom_addr,
    input  logic [W-1:0]        rom_dat,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W-1:0]        out_dat
);

    l_state_e          state;
    l_state_e          state_nxt;
    logic [STEP_W-1:0] step;
    logic              issue_d;
    logic [W-1:0]      acc;
    logic [W-1:0]      blk;
    logic              accept;

    assign accept  = in_valid & in_ready;
    assign out_dat = acc;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept)            state_nxt = S_ISSUE;
            S_ISSUE: if (step == LAST_STEP) state_nxt = S_DRAIN;
            S_DRAIN:                        state_nxt = S_DONE;
            S_DONE:  if (out_ready)         state_nxt = S_IDLE;
            default:                        state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs decoded from state; in_ready is held low during reset
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        rom_sel   = '0;
        rom_addr  = '0;
        case (state)
            S_IDLE:  in_ready = reset_n;
            S_ISSUE: begin
                rom_sel  = step;
                rom_addr = blk[{step, 3'b000} +: BYTE_W];
            end
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: latched block, step counter, delayed issue flag, accumulator
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            step    <= '0;
            issue_d <= 1'b0;
            acc     <= '0;
            blk     <= '0;
        end else begin
            // ROM data lands one cycle after its issue cycle
            issue_d <= (state == S_ISSUE);
            if (accept) begin
                blk  <= in_dat;
                acc  <= '0;
                step <= '0;
            end else begin
                if (state == S_ISSUE) begin
                    step <= step + STEP_W'(1);
                end
                if (issue_d) begin
                    acc <= acc ^ rom_dat;
                end
            end
        end
    end

endmodule

// File: tb/tb_l_seq.sv
// Directed testbench for l_seq with a behavioural L-table ROM bank and an
// independent golden L-transform (16 rounds of the linear R step).
module tb_l_seq;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_dat;
    logic [3:0]   rom_sel;
    logic [7:0]   rom_addr;
    logic [127:0] rom_dat;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_dat;

    int tests;
    int fails;

    l_seq #(.W(128)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dat    (in_dat),
        .rom_sel   (rom_sel),
        .rom_addr  (rom_addr),
        .rom_dat   (rom_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dat   (out_dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // GF(2^8) multiply, modulus x^8 + x^7 + x^6 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'hC3) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Linear-function coefficient applied to byte position i
    function automatic logic [7:0] coef(input int i);
        case (i)
            0:  return 8'd1;
            1:  return 8'd148;
            2:  return 8'd32;
            3:  return 8'd133;
            4:  return 8'd16;
            5:  return 8'd194;
            6:  return 8'd192;
            7:  return 8'd1;
            8:  return 8'd251;
            9:  return 8'd1;
            10: return 8'd192;
            11: return 8'd194;
            12: return 8'd16;
            13: return 8'd133;
            14: return 8'd32;
            default: return 8'd148;
        endcase
    endfunction

    // Full L-transform: 16 applications of R
    function automatic logic [127:0] l_ref(input logic [127:0] blk);
        logic [127:0] a;
        logic [7:0]   t;
        a = blk;
        for (int r = 0; r < 16; r++) begin
            t = 8'h00;
            for (int i = 0; i < 16; i++) begin
                t = t ^ gf_mul(a[8*i +: 8], coef(i));
            end
            a = {t, a[127:8]};
        end
        return a;
    endfunction

    // ROM bank model: T_sel[addr] = L(addr placed at byte position sel), 1-cycle read
    always @(posedge clk) begin
        rom_dat <= l_ref(128'(rom_addr) << {rom_sel, 3'b000});
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer a block from a negedge; returns at the negedge after the accept edge
    task automatic send_block(input logic [127:0] d, output bit ok);
        bit take;
        ok       = 1'b0;
        in_dat   = d;
        in_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            take = in_ready;
            @(negedge clk);
            if (take) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Cycles counted from 1 = the cycle right after the accept edge
    task automatic wait_result(output int n);
        n = 1;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_dat    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        tests++;
        if (out_valid !== 1'b0 || out_dat !== 128'h0) begin
            fails++; $display("FAIL reset_out: valid=%b dat=%h expected 0/0", out_valid, out_dat);
        end
        tests++;
        if (rom_sel !== 4'h0 || rom_addr !== 8'h00) begin
            fails++; $display("FAIL reset_rom: sel=%h addr=%h expected 0/0", rom_sel, rom_addr);
        end
        reset_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_zero();
        bit ok;
        int n;
        out_ready = 1'b1;
        send_block(128'h0, ok);
        tests++;
        if (!ok) begin
            fails++; $display("FAIL zero_accept: got no accept expected accept");
        end
        wait_result(n);
        tests++;
        if (n != 18) begin
            fails++; $display("FAIL zero_latency: got %0d expected 18", n);
        end
        tests++;
        if (out_dat !== 128'h0) begin
            fails++; $display("FAIL zero_data: got %h expected 0", out_dat);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL zero_return_idle: valid=%b ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_vector();
        bit ok;
        int n;
        out_ready = 1'b1;
        send_block(128'h64a59400000000000000000000000000, ok);
        wait_result(n);
        tests++;
        if (!ok || out_valid !== 1'b1 || out_dat !== 128'hd456584dd0e3e84cc3166e4b7fa2890d) begin
            fails++;
            $display("FAIL std_vector: got %h (valid=%b) expected d456584dd0e3e84cc3166e4b7fa2890d",
                     out_dat, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bit           ok;
        int           n;
        logic [127:0] d;
        logic [127:0] d2;
        logic [127:0] exp_v;
        d         = rnd128();
        d2        = rnd128();
        exp_v     = l_ref(d);
        out_ready = 1'b0;
        send_block(d, ok);
        wait_result(n);
        tests++;
        if (out_valid !== 1'b1 || out_dat !== exp_v) begin
            fails++; $display("FAIL bp_first: valid=%b dat=%h expected 1/%h", out_valid, out_dat, exp_v);
        end
        in_dat   = d2;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || out_dat !== exp_v || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b dat=%h expected 1/0/%h",
                         i, out_valid, in_ready, out_dat, exp_v);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || rom_sel !== 4'h0) begin
            fails++;
            $display("FAIL bp_handshake_idle: valid=%b ready=%b sel=%h expected 0/1/0",
                     out_valid, in_ready, rom_sel);
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0 || rom_addr !== d2[7:0]) begin
            fails++;
            $display("FAIL bp_next_accept: ready=%b addr=%h expected 0/%h", in_ready, rom_addr, d2[7:0]);
        end
        wait_result(n);
        tests++;
        if (out_valid !== 1'b1 || out_dat !== l_ref(d2)) begin
            fails++; $display("FAIL bp_next_data: got %h expected %h", out_dat, l_ref(d2));
        end
        @(negedge clk);
    endtask

    task automatic test_issue_seq();
        bit           ok;
        logic [127:0] d;
        d         = rnd128();
        out_ready = 1'b1;
        send_block(d, ok);
        in_dat = ~d;
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (rom_sel !== 4'(k) || rom_addr !== d[8*k +: 8]) begin
                fails++;
                $display("FAIL issue_step%0d: sel=%h addr=%h expected %h/%h",
                         k, rom_sel, rom_addr, 4'(k), d[8*k +: 8]);
            end
            @(negedge clk);
        end
        tests++;
        if (rom_sel !== 4'h0 || rom_addr !== 8'h00 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL issue_drain: sel=%h addr=%h valid=%b expected 0/0/0", rom_sel, rom_addr, out_valid);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_dat !== l_ref(d)) begin
            fails++;
            $display("FAIL issue_result: valid=%b dat=%h expected 1/%h", out_valid, out_dat, l_ref(d));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit           ok;
        bit           seen;
        int           n;
        logic [127:0] d;
        logic [127:0] d2;
        d         = rnd128();
        d2        = rnd128();
        out_ready = 1'b1;
        send_block(d, ok);
        repeat (7) @(negedge clk);
        tests++;
        if (rom_sel !== 4'h7) begin
            fails++; $display("FAIL rst_mid_step: sel=%h expected 7", rom_sel);
        end
        reset_n = 1'b0;
        @(negedge clk);
        tests++;
        if (rom_sel !== 4'h0 || rom_addr !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_abort: sel=%h addr=%h valid=%b ready=%b expected 0/0/0/0",
                     rom_sel, rom_addr, out_valid, in_ready);
        end
        reset_n = 1'b1;
        seen    = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++; $display("FAIL rst_mid_no_result: got out_valid expected none");
        end
        send_block(d2, ok);
        wait_result(n);
        tests++;
        if (!ok || out_valid !== 1'b1 || out_dat !== l_ref(d2)) begin
            fails++; $display("FAIL rst_mid_next: got %h expected %h", out_dat, l_ref(d2));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] blks [100];
        logic [127:0] exps [100];
        int           ni;
        int           no;
        int           cyc;
        int           last;
        bit           take;
        for (int i = 0; i < 100; i++) begin
            blks[i] = rnd128();
            exps[i] = l_ref(blks[i]);
        end
        out_ready = 1'b1;
        in_dat    = blks[0];
        in_valid  = 1'b1;
        ni        = 0;
        no        = 0;
        cyc       = 0;
        last      = -1;
        while (no < 100 && cyc < 2300) begin
            if (out_valid) begin
                tests++;
                if (out_dat !== exps[no]) begin
                    fails++; $display("FAIL b2b_data%0d: got %h expected %h", no, out_dat, exps[no]);
                end
                if (last >= 0) begin
                    tests++;
                    if (cyc - last != 19) begin
                        fails++; $display("FAIL b2b_gap%0d: got %0d expected 19", no, cyc - last);
                    end
                end
                last = cyc;
                no++;
            end
            take = in_valid && in_ready;
            @(negedge clk);
            cyc++;
            if (take) begin
                ni++;
                if (ni < 100) in_dat = blks[ni];
                else          in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        tests++;
        if (no != 100) begin
            fails++; $display("FAIL b2b_count: got %0d results expected 100", no);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_zero();
        test_vector();
        test_backpressure();
        test_issue_seq();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global bound so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
